// File: rtl/clk_period_meter_if.sv
// Measurement bundle between a divided-clock source and its period meter.
// The master side owns sig_in; the slave (meter) side reports the results.
interface clk_period_meter_if #(
  parameter int CNT_W = 32
);
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             stalled;

  modport master (
    output sig_in,
    input  period, high_time, meas_valid, locked, stalled
  );

  modport slave (
    input  sig_in,
    output period, high_time, meas_valid, locked, stalled
  );
endinterface

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow, asynchronous clock in clk cycles.
// Reports lock once the period repeats and flags a stall when edges stop.
module clk_period_meter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000,
  parameter int LOCK_N  = 4
) (
  input  logic              clk,
  input  logic              rst,
  clk_period_meter_if.slave mbus
);

  localparam int               MW        = $clog2(LOCK_N);
  localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_N - 1);
  localparam logic [CNT_W-1:0] CNT_TO    = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           r_state, w_state_next;
  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [CNT_W-1:0] r_hcap, w_hcap_next;
  logic [CNT_W-1:0] r_period, w_period_next;
  logic [CNT_W-1:0] r_high, w_high_next;
  logic [CNT_W-1:0] r_prev_period, w_prev_period_next;
  logic [MW-1:0]    r_match, w_match_next;
  logic             r_meas_valid, w_meas_valid_next;
  logic             r_locked, w_locked_next;
  logic             r_stalled, w_stalled_next;
  logic             r_first, w_first_next;

  logic             w_rise, w_fall;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [MW-1:0]    w_match_inc;

  assign w_rise      = r_s2 & ~r_s3;
  assign w_fall      = ~r_s2 & r_s3;
  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_match_inc = (r_match == MATCH_MAX) ? r_match : r_match + MW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s3          <= 1'b0;
      r_cnt         <= '0;
      r_hcap        <= '0;
      r_period      <= '0;
      r_high        <= '0;
      r_prev_period <= '0;
      r_match       <= '0;
      r_meas_valid  <= 1'b0;
      r_locked      <= 1'b0;
      r_stalled     <= 1'b0;
      r_first       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_s1          <= mbus.sig_in;
      r_s2          <= r_s1;
      r_s3          <= r_s2;
      r_cnt         <= w_cnt_next;
      r_hcap        <= w_hcap_next;
      r_period      <= w_period_next;
      r_high        <= w_high_next;
      r_prev_period <= w_prev_period_next;
      r_match       <= w_match_next;
      r_meas_valid  <= w_meas_valid_next;
      r_locked      <= w_locked_next;
      r_stalled     <= w_stalled_next;
      r_first       <= w_first_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_hcap_next        = r_hcap;
    w_period_next      = r_period;
    w_high_next        = r_high;
    w_prev_period_next = r_prev_period;
    w_match_next       = r_match;
    w_meas_valid_next  = 1'b0;
    w_locked_next      = r_locked;
    w_stalled_next     = r_stalled;
    w_first_next       = r_first;

    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_rise) begin
          w_stalled_next = 1'b0;
          w_first_next   = 1'b1;
          w_state_next   = MEASURE;
        end
      end
      MEASURE: begin
        if (w_rise) begin
          w_period_next      = w_cnt_inc;
          w_high_next        = r_hcap;
          w_meas_valid_next  = 1'b1;
          w_cnt_next         = '0;
          w_prev_period_next = w_cnt_inc;
          w_first_next       = 1'b0;
          // The first period after IDLE has nothing to compare against.
          if (!r_first && (w_cnt_inc == r_prev_period)) begin
            w_match_next  = w_match_inc;
            w_locked_next = (w_match_inc == MATCH_MAX);
          end else begin
            w_match_next  = '0;
            w_locked_next = 1'b0;
          end
        end else if (r_cnt == CNT_TO) begin
          w_stalled_next = 1'b1;
          w_locked_next  = 1'b0;
          w_match_next   = '0;
          w_cnt_next     = '0;
          w_state_next   = IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
          if (w_fall) begin
            w_hcap_next = w_cnt_inc;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign mbus.period     = r_period;
  assign mbus.high_time  = r_high;
  assign mbus.meas_valid = r_meas_valid;
  assign mbus.locked     = r_locked;
  assign mbus.stalled    = r_stalled;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: table of source ratios checked through a
// measurement scoreboard, plus stall, async reset and timeout-boundary sequences.
module tb_clk_period_meter;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clk_period_meter_if #(.CNT_W(W)) bus_a ();
  clk_period_meter_if #(.CNT_W(W)) bus_b ();

  clk_period_meter #(.CNT_W(W), .TIMEOUT(100), .LOCK_N(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .mbus(bus_a)
  );

  clk_period_meter #(.CNT_W(W), .TIMEOUT(8), .LOCK_N(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .mbus(bus_b)
  );

  typedef struct {
    int high;
    int low;
    int reps;
    int exp_period;
    int exp_high;
    int lock_from;
  } vec_t;

  typedef struct {
    int period;
    int high;
    bit locked;
  } exp_t;

  vec_t vecs[5];
  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk_b = 1'b0;
  int   b_meas = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Sets the selected source for h high then l low cycles, changing on negedges.
  task automatic drive_period(input int h, input int l, input bit sel);
    for (int i = 0; i < h + l; i++) begin
      if (sel) bus_b.sig_in = (i < h);
      else     bus_a.sig_in = (i < h);
      @(negedge clk);
    end
  endtask

  task automatic push_exp(input int p, input int h, input bit lk);
    exp_t e;
    e.period = p;
    e.high   = h;
    e.locked = lk;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus_a.meas_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_meas: got period %0d want no measurement", bus_a.period);
      end else begin
        e = sb_q.pop_front();
        $display("meas a: period=%0d high=%0d locked=%0b", bus_a.period, bus_a.high_time, bus_a.locked);
        check("period", bus_a.period, e.period);
        check("high_time", bus_a.high_time, e.high);
        check("locked", bus_a.locked, e.locked);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_b) begin
      check("b_stalled", bus_b.stalled, 0);
      if (bus_b.meas_valid) begin
        b_meas++;
        $display("meas b: period=%0d high=%0d locked=%0b", bus_b.period, bus_b.high_time, bus_b.locked);
        check("b_period", bus_b.period, 8);
        check("b_high", bus_b.high_time, 4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    vecs[0] = '{2, 2, 5, 4, 2, 4};
    vecs[1] = '{3, 4, 5, 7, 3, 4};
    vecs[2] = '{1, 1, 6, 2, 1, 4};
    vecs[3] = '{5, 5, 5, 10, 5, 4};
    vecs[4] = '{3, 3, 5, 6, 3, 4};

    bus_a.sig_in = 1'b0;
    bus_b.sig_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", bus_a.period, 0);
    check("rst_high", bus_a.high_time, 0);
    check("rst_valid", bus_a.meas_valid, 0);
    check("rst_locked", bus_a.locked, 0);
    check("rst_stalled", bus_a.stalled, 0);
    rst = 1'b0;
    @(negedge clk);

    // Each period is measured by the rise that starts the next one.
    foreach (vecs[v]) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        drive_period(vecs[v].high, vecs[v].low, 1'b0);
        push_exp(vecs[v].exp_period, vecs[v].exp_high, (r + 1) >= vecs[v].lock_from);
      end
    end

    // Final rise closes the last ratio-6 period, then the source goes quiet.
    bus_a.sig_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_a.meas_valid && n < 10);
    check("flush_seen", bus_a.meas_valid, 1);
    bus_a.sig_in = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_stall_stalled", bus_a.stalled, 0);
    check("pre_stall_locked", bus_a.locked, 1);
    @(negedge clk);
    check("stall_stalled", bus_a.stalled, 1);
    check("stall_locked", bus_a.locked, 0);
    check("stall_period", bus_a.period, 6);
    check("stall_high", bus_a.high_time, 3);
    check("stall_sb_empty", sb_q.size(), 0);

    // Recovery: first rise only restarts timing, second one measures.
    drive_period(5, 5, 1'b0);
    check("recover_stalled", bus_a.stalled, 0);
    push_exp(10, 5, 1'b0);
    for (int r = 0; r < 5; r++) begin
      drive_period(2, 2, 1'b0);
      push_exp(4, 2, (r + 1) >= 4);
    end
    bus_a.sig_in = 1'b1;
    wait_drain(10);
    check("pre_rst_locked", bus_a.locked, 1);

    // Asynchronous reset in the middle of a high phase.
    #1 rst = 1'b1;
    #1;
    check("arst_period", bus_a.period, 0);
    check("arst_high", bus_a.high_time, 0);
    check("arst_valid", bus_a.meas_valid, 0);
    check("arst_locked", bus_a.locked, 0);
    check("arst_stalled", bus_a.stalled, 0);
    @(negedge clk);
    bus_a.sig_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_period(3, 3, 1'b0);
    push_exp(6, 3, 1'b0);
    drive_period(3, 3, 1'b0);
    push_exp(6, 3, 1'b0);
    bus_a.sig_in = 1'b1;
    wait_drain(10);
    bus_a.sig_in = 1'b0;

    // Period equal to TIMEOUT: the rise lands on the timeout cycle and wins.
    chk_b = 1'b1;
    for (int r = 0; r < 6; r++) drive_period(4, 4, 1'b1);
    chk_b = 1'b0;
    check("b_meas_count", b_meas, 5);
    check("b_locked", bus_b.locked, 1);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receiving end for divided clocks generated elsewhere in the design, e.g. VGA pixel and refresh clocks.
- Samples a slow clock or periodic signal in the fast `clk` domain.
- Measures its period and high time in `clk` cycles and reports a lock status once the ratio is stable.
- Used to self-check divider outputs on hardware and to gate downstream logic until the divided clock is stable.

Parameters:
CNT_W, 32, width of internal counter and of `period` / `high_time` outputs
TIMEOUT, 1000000, clk cycles without a rising edge before `stalled` asserts; must be ≥2 and < 2^CNT_W
LOCK_N, 4, consecutive identical period measurements required for `locked`; must be ≥2

Ports:
clk  input  1  fast reference clock
rst  input  1  reset, asynchronous, active-high
sig_in  input  1  divided clock or periodic signal, asynchronous to `clk`
period  output  CNT_W  last measured period (rising edge to rising edge), in clk cycles
high_time  output  CNT_W  high duration within the last measured period, in clk cycles
meas_valid  output  1  one-cycle pulse when `period` / `high_time` update
locked  output  1  LOCK_N consecutive identical periods seen
stalled  output  1  no rising edge for TIMEOUT cycles

Behaviour:
- Reset (async, immediate): `period`=0, `high_time`=0, `meas_valid`=0, `locked`=0, `stalled`=0. Synchronizer flops, counter, match counter and `hcap` are all 0. State = IDLE.
- Input path:
  - Two-flop synchronizer `s1`→`s2`, plus history flop `s3`.
  - `rise` = `s2` & ~`s3`; `fall` = ~`s2` & `s3`.
  - Edge detected on the 2nd clk edge after `sig_in` is first sampled high; outputs update on the 3rd.
- States: IDLE, MEASURE.
- IDLE:
  - `cnt` held at 0.
  - On `rise`: `cnt`<=0, `stalled`<=0, go to MEASURE. No `meas_valid` (first edge only starts timing).
- MEASURE, each cycle without `rise`:
  - `cnt`<=`cnt`+1, saturating at all-ones.
  - On `fall`: `hcap`<=`cnt`+1.
- MEASURE, on `rise`:
  - `period`<=`cnt`+1.
  - `high_time`<=`hcap`.
  - `meas_valid`<=1 for exactly one cycle.
  - `cnt`<=0.
  - Remain in MEASURE.
- Lock logic, evaluated on each MEASURE `rise`:
  - Compare new period with `prev_period`.
  - Equal: `match_cnt` increments, saturating at LOCK_N-1.
  - Differs: `match_cnt`<=0 and `locked`<=0 in the same cycle `meas_valid` asserts.
  - `locked`<=1 when `match_cnt` reaches LOCK_N-1, i.e. LOCK_N equal consecutive periods.
  - `prev_period`<=new period on every measurement.
  - The first measurement after IDLE has no predecessor: `match_cnt`<=0.
- Timeout:
  - In MEASURE, if `cnt` == TIMEOUT-1 and no `rise` that cycle: `stalled`<=1, `locked`<=0, `match_cnt`<=0, go to IDLE.
  - `period` / `high_time` keep their last values.
- Simultaneous `rise` and timeout in the same cycle: `rise` wins; normal measurement, no stall.
- `fall` and `rise` cannot coincide: they are mutually exclusive by construction.
- Period of 2 (`sig_in` toggling every clk) is the minimum supported. Shorter pulses are filtered or aliased by the synchronizer and are out of scope.
- Async `rst` mid-period discards the partial measurement. The first rise after reset behaves as the IDLE case.

Test Plan:
- Divide-by-4 source (2 high / 2 low, synchronous) → from the 2nd rise onward `period`=4, `high_time`=2, `meas_valid` 1 cycle per period. `locked`=1 on the 4th `meas_valid` with LOCK_N=4.
- Odd divide-by-7, high 3 / low 4 → `period`=7, `high_time`=3. Toggle every clk → `period`=2, `high_time`=1.
- Locked at ratio 10, switch source to ratio 6:
  - The first 6-cycle measurement (or a transitional value) drops `locked` in its `meas_valid` cycle.
  - `locked` reasserts after 4 equal measurements of 6.
- TIMEOUT=100, `sig_in` held low after a rise:
  - `stalled`=1 and `locked`=0 exactly 100 cycles after the rise was detected; `period` unchanged.
  - Next rise clears `stalled` without `meas_valid`; the following rise yields a valid `period`.
- Assert `rst` asynchronously mid-period while locked → all outputs 0 immediately, without waiting for a `clk` edge. After release, the first rise gives no `meas_valid`; the second gives a correct `period`.
- Boundary: TIMEOUT=8 with source period exactly 8 → `rise` coincides with the timeout cycle, so no stall and `period`=8 every cycle.
